reduce_gate_serial_v: RTL and testbench
=======================================

Name: reduce_gate_serial_v

Overview:
- Parametrised, sequential successor to the fixed 4-input NAND gate.
- Reduces a WIDTH-bit input vector to one bit with a run-time selectable gate function: AND, NAND, OR, NOR, XOR or XNOR.
- Processes CHUNK bits per clock under a start/busy/done handshake.
- Lets the datapath evaluate wide gate reductions with a small, narrow combining stage.

Parameters:
- WIDTH, 16, total number of gate inputs; must be a multiple of CHUNK and at least CHUNK.
- CHUNK, 4, inputs combined per clock cycle.
- (derived) N = WIDTH/CHUNK, number of processing cycles; the count register is clog2(N)+1 bits.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_start  input  1  request; sampled only in IDLE.
- i_abort  input  1  cancel the current operation; no done pulse.
- i_op  input  3  gate select, captured at start: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 11x reserved.
- i_data  input  WIDTH  gate inputs, captured at start; bit 0 is processed first.
- o_busy  output  1  high in RUN and DONE.
- o_done  output  1  one-cycle pulse; result valid.
- o_f  output  1  reduction result; holds its value until the next done.
- o_err  output  1  reserved op flag; updated together with o_done.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - state=IDLE; o_busy, o_done, o_f, o_err all 0.
  - Shift register, accumulator and count cleared.
  - Reset has priority over every other input, including mid-operation: the result is discarded and no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - o_busy=0, o_done=0.
  - On an edge with i_start=1, capture i_data into the shift register and i_op into the op register.
  - Accumulator init: 1 for AND/NAND; 0 for OR/NOR/XOR/XNOR/reserved.
  - cnt=0, then go to RUN.
- RUN, each edge:
  - acc = acc op-combined with shreg[CHUNK-1:0]; AND-family uses AND-reduce, OR-family uses OR-reduce, XOR-family uses XOR-reduce.
  - shreg shifts right by CHUNK; cnt increments.
  - At the edge where cnt==N-1, go to DONE and register the outputs at that edge:
    - o_f = final acc, inverted for NAND/NOR/XNOR.
    - o_done=1.
    - Reserved op: o_f=0, o_err=1. Otherwise o_err=0.
- DONE: lasts one cycle with o_done=1; the next edge clears o_done and returns to IDLE.
- Timing: start sampled at edge E0; o_done and o_f visible after edge E_N (latency N cycles); IDLE after E_{N+1}. Minimum start-to-start spacing is N+2 cycles.
- i_start while o_busy=1 is ignored: no capture, no effect on the current operation.
- i_abort=1 in RUN or DONE: next edge goes to IDLE, o_done=0, and o_f/o_err keep their previous values.
  - i_abort in IDLE is ignored.
  - i_abort and i_start on the same IDLE edge: the start wins.
- i_data and i_op changes after capture have no effect on the current result.
- N=1 (CHUNK=WIDTH): RUN lasts one edge; o_done appears after E1.

Test Plan:
1. Reset mid-RUN: WIDTH=16, CHUNK=4, i_op=001, i_data=16'hFFFF, i_rst_n=0 at E2 -> all outputs 0 after E2, no done pulse, state IDLE.
2. NAND: i_op=001, i_data=16'hFFFF, start at E0 -> o_done=1 only in the cycle after E4, o_f=0; repeat with 16'hFFF7 -> o_f=1; o_busy=1 from after E0 through E5.
3. Other ops on i_data=16'h0100:
   - OR -> o_f=1.
   - NOR -> 0.
   - XOR -> 1.
   - XNOR -> 0.
   - AND -> 0.
   - 16'h0000 with NOR -> 1.
4. Ignored start and data change: i_start pulsed at E2 and E5 with different i_data and i_op -> no effect; the first result is unchanged; the next start is accepted at E6 or later.
5. Abort: i_abort=1 at E2 -> IDLE after E2, no o_done, and o_f keeps its prior value (1 from the preceding run).
6. Reserved op: i_op=110 -> o_done after E4 with o_err=1, o_f=0; the following valid op clears o_err to 0 at its done.

Source files
------------

// File: rtl/reduce_gate_serial_v.sv
// Serial gate-reduction unit: folds a WIDTH-bit vector into one bit using a
// run-time selected AND/NAND/OR/NOR/XOR/XNOR, consuming CHUNK bits per clock.
module reduce_gate_serial_v #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_f,
   output logic             o_err
);

   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [2:0]       op_q, op_d;
   logic             acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             f_q, f_d;
   logic             err_q, err_d;

   logic [CHUNK-1:0] chunk;
   logic             acc_next;
   logic             op_reserved;

   // Fold the current low chunk into the accumulator for the captured op family.
   always_comb begin
      chunk       = shreg_q[CHUNK-1:0];
      op_reserved = (op_q[2:1] == 2'b11);
      acc_next    = acc_q;
      case (op_q[2:1])
         2'b00:   acc_next = acc_q & (&chunk);
         2'b01:   acc_next = acc_q | (|chunk);
         2'b10:   acc_next = acc_q ^ (^chunk);
         default: acc_next = acc_q;
      endcase
   end

   // Next-state and datapath update for the IDLE/RUN/DONE handshake.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      op_d    = op_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      f_d     = f_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               shreg_d = i_data;
               op_d    = i_op;
               acc_d   = (i_op[2:1] == 2'b00);
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (i_abort) begin
               state_d = ST_IDLE;
            end else begin
               acc_d   = acc_next;
               shreg_d = shreg_q >> CHUNK;
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == LAST_CNT) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  f_d     = op_reserved ? 1'b0 : (acc_next ^ op_q[0]);
                  err_d   = op_reserved;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         op_q    <= '0;
         acc_q   <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         f_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         f_q     <= f_d;
         err_q   <= err_d;
      end
   end

   assign o_busy = (state_q != ST_IDLE);
   assign o_done = done_q;
   assign o_f    = f_q;
   assign o_err  = err_q;

endmodule

// File: tb/tb_reduce_gate_serial_v.sv
// Directed bench for reduce_gate_serial_v (WIDTH=16, CHUNK=4, latency 4).
module tb_reduce_gate_serial_v;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned CHUNK = 4;

   logic             i_clk;
   logic             i_rst_n;
   logic             i_start;
   logic             i_abort;
   logic [2:0]       i_op;
   logic [WIDTH-1:0] i_data;
   logic             o_busy;
   logic             o_done;
   logic             o_f;
   logic             o_err;

   int unsigned n_cmp;
   int unsigned n_bad;

   typedef struct {
      logic [2:0]       op;
      logic [WIDTH-1:0] data;
      logic             exp_f;
      logic             exp_err;
   } vec_t;

   vec_t vecs[14];

   reduce_gate_serial_v #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (i_start),
      .i_abort (i_abort),
      .i_op    (i_op),
      .i_data  (i_data),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_f     (o_f),
      .o_err   (o_err)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Start one operation, scramble inputs after capture, check latency/result.
   task automatic run_op(input string tag, input logic [2:0] op,
                         input logic [WIDTH-1:0] data,
                         input logic exp_f, input logic exp_err);
      int lat;
      i_start = 1'b1;
      i_op    = op;
      i_data  = data;
      tick();
      i_start = 1'b0;
      i_op    = op ^ 3'b001;
      i_data  = ~data;
      check({tag, " busy after start"}, int'(o_busy), 1);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (o_done) begin
            lat = k;
            break;
         end
      end
      check({tag, " latency"}, lat, 4);
      check({tag, " f"}, int'(o_f), int'(exp_f));
      check({tag, " err"}, int'(o_err), int'(exp_err));
      check({tag, " busy in done"}, int'(o_busy), 1);
      tick();
      check({tag, " done cleared"}, int'(o_done), 0);
      check({tag, " idle after done"}, int'(o_busy), 0);
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      i_rst_n = 1'b0;
      i_start = 1'b0;
      i_abort = 1'b0;
      i_op    = 3'b000;
      i_data  = '0;

      vecs[0]  = '{3'b001, 16'hFFFF, 1'b0, 1'b0};
      vecs[1]  = '{3'b001, 16'hFFF7, 1'b1, 1'b0};
      vecs[2]  = '{3'b010, 16'h0100, 1'b1, 1'b0};
      vecs[3]  = '{3'b011, 16'h0100, 1'b0, 1'b0};
      vecs[4]  = '{3'b100, 16'h0100, 1'b1, 1'b0};
      vecs[5]  = '{3'b101, 16'h0100, 1'b0, 1'b0};
      vecs[6]  = '{3'b000, 16'h0100, 1'b0, 1'b0};
      vecs[7]  = '{3'b011, 16'h0000, 1'b1, 1'b0};
      vecs[8]  = '{3'b000, 16'hFFFF, 1'b1, 1'b0};
      vecs[9]  = '{3'b100, 16'h0103, 1'b1, 1'b0};
      vecs[10] = '{3'b101, 16'h0003, 1'b1, 1'b0};
      vecs[11] = '{3'b110, 16'hFFFF, 1'b0, 1'b1};
      vecs[12] = '{3'b111, 16'h0000, 1'b0, 1'b1};
      vecs[13] = '{3'b010, 16'h0001, 1'b1, 1'b0};

      tick();
      tick();
      check("reset busy", int'(o_busy), 0);
      check("reset done", int'(o_done), 0);
      check("reset f", int'(o_f), 0);
      check("reset err", int'(o_err), 0);
      i_rst_n = 1'b1;
      tick();

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].data,
                vecs[i].exp_f, vecs[i].exp_err);

      // Start ignored while busy; inputs changed after capture.
      i_start = 1'b1; i_op = 3'b001; i_data = 16'hFFF7;
      for (int k = 0; k <= 5; k++) begin
         tick();
         i_start = (k == 1 || k == 4);
         i_op    = 3'b000;
         i_data  = 16'h0000;
         check($sformatf("ign busy E%0d", k), int'(o_busy), (k <= 4) ? 1 : 0);
         check($sformatf("ign done E%0d", k), int'(o_done), (k == 4) ? 1 : 0);
         if (k == 4) check("ign f", int'(o_f), 1);
      end
      i_start = 1'b0;
      run_op("after ign", 3'b010, 16'h0000, 1'b0, 1'b0);

      // Abort mid-RUN keeps previous result.
      run_op("pre abort", 3'b001, 16'hFFF7, 1'b1, 1'b0);
      i_start = 1'b1; i_abort = 1'b1; i_op = 3'b010; i_data = 16'h0000;
      tick();
      check("start beats abort", int'(o_busy), 1);
      i_start = 1'b0; i_abort = 1'b0;
      tick();
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      check("abort busy", int'(o_busy), 0);
      check("abort done", int'(o_done), 0);
      check("abort f kept", int'(o_f), 1);
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 6; k++) begin
            tick();
            if (o_done) seen++;
         end
         check("abort no late done", seen, 0);
      end
      i_abort = 1'b1;
      tick();
      check("abort in idle ignored", int'(o_busy), 0);
      i_abort = 1'b0;

      // Reset mid-RUN discards the result.
      run_op("pre reset", 3'b001, 16'hFFF7, 1'b1, 1'b0);
      run_op("pre reset err", 3'b110, 16'h0000, 1'b0, 1'b1);
      i_start = 1'b1; i_op = 3'b001; i_data = 16'hFFFF;
      tick();
      i_start = 1'b0;
      tick();
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      check("rst mid busy", int'(o_busy), 0);
      check("rst mid done", int'(o_done), 0);
      check("rst mid f", int'(o_f), 0);
      check("rst mid err", int'(o_err), 0);
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 6; k++) begin
            tick();
            if (o_done || o_busy) seen++;
         end
         check("rst mid stays idle", seen, 0);
      end
      run_op("after reset", 3'b100, 16'h0100, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
